// File: rtl/router_pkg.sv
// Shared router definitions: flit width, default link credit depth and
// the transmitter status encoding.
package router_pkg;

   localparam int FLIT_W       = 8;
   localparam int LINK_CREDITS = 4;

   // Link status as seen from the sender. The sticky error is a separate bit.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,   // every credit home, nothing outstanding
      BUSY  = 2'd1,   // some credits outstanding, some left
      STALL = 2'd2    // no credits, sender must wait
   } credit_state_e;

endpackage

// File: rtl/credit_tx_if.sv
// Flit handshake bundle for credit_tx.
//   in_valid/in_ready/in_data : upstream arbiter -> transmitter (valid/ready)
//   out_valid/out_data        : transmitter -> link pipeline (registered)
// master: the transmitter's view; slave: the surrounding logic's view.
interface credit_tx_if
   import router_pkg::*;
#(
   parameter int WIDTH = FLIT_W
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;

   modport master (
      input  in_valid, in_data,
      output in_ready, out_valid, out_data
   );

   modport slave (
      output in_valid, in_data,
      input  in_ready, out_valid, out_data
   );
endinterface

// File: rtl/credit_counter.sv
// Up/down saturating credit counter with a sticky overflow flag.
//   clk, rst_n  : clock, async active-low reset (count resets to CREDITS)
//   inc_i       : one credit returned
//   dec_i       : one credit consumed
//   cnt_o       : registered count
//   cnt_nxt_o   : count after this cycle's update (for status tracking)
//   ovf_o       : sticky, set by an increment while already full
module credit_counter #(
   parameter int CREDITS = 4,
   parameter int CNT_W   = $clog2(CREDITS + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc_i,
   input  logic             dec_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic [CNT_W-1:0] cnt_nxt_o,
   output logic             ovf_o
);
   localparam logic [CNT_W-1:0] MAX = CNT_W'(CREDITS);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;

   always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      case ({dec_i, inc_i})
         2'b10: if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
         2'b01: begin
            // A credit with nothing outstanding saturates and flags the fault.
            if (cnt_q == MAX) ovf_d = 1'b1;
            else              cnt_d = cnt_q + CNT_W'(1);
         end
         default: ;  // idle, or consume+return which cancel out
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= MAX;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   assign cnt_o     = cnt_q;
   assign cnt_nxt_o = cnt_d;
   assign ovf_o     = ovf_q;
endmodule

// File: rtl/credit_tx.sv
// Credit-based link transmitter. Accepts flits over valid/ready, launches
// them registered into the link, and spends one credit per flit; credits
// come back as single-cycle pulses on credit_in.
//   clk, rst_n  : clock, async active-low reset
//   link        : credit_tx_if.master (upstream handshake + link output)
//   credit_in   : one pulse per freed receiver slot
//   credit_cnt  : registered credit count
//   idle        : all credits home
//   err         : sticky credit overflow
module credit_tx
   import router_pkg::*;
#(
   parameter int WIDTH   = FLIT_W,
   parameter int CREDITS = LINK_CREDITS,
   parameter int CNT_W   = $clog2(CREDITS + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   credit_tx_if.master      link,
   input  logic             credit_in,
   output logic [CNT_W-1:0] credit_cnt,
   output logic             idle,
   output logic             err
);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(CREDITS);

   logic             xfer;
   logic [CNT_W-1:0] cnt_nxt;
   credit_state_e    state_q, state_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;

   assign xfer = link.in_valid && link.in_ready;

   credit_counter #(
      .CREDITS (CREDITS),
      .CNT_W   (CNT_W)
   ) u_credit_counter (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc_i     (credit_in),
      .dec_i     (xfer),
      .cnt_o     (credit_cnt),
      .cnt_nxt_o (cnt_nxt),
      .ovf_o     (err)
   );

   // Status tracks the count the counter will hold next cycle, so in_ready
   // and idle are pure decodes of registered state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (cnt_nxt != FULL)
                   state_d = (cnt_nxt == '0) ? STALL : BUSY;
         BUSY:  if (cnt_nxt == FULL)     state_d = IDLE;
                else if (cnt_nxt == '0)  state_d = STALL;
         STALL: if (credit_in)
                   state_d = (cnt_nxt == FULL) ? IDLE : BUSY;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      out_valid_d = xfer;
      out_data_d  = xfer ? link.in_data : out_data_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign link.in_ready  = (state_q != STALL);
   assign link.out_valid = out_valid_q;
   assign link.out_data  = out_data_q;
   assign idle           = (state_q == IDLE);
endmodule

// File: tb/tb_credit_tx.sv
module tb_credit_tx;
   import router_pkg::*;

   localparam int CR    = 4;
   localparam int CNT_W = $clog2(CR + 1);

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             credit_in = 1'b0;
   logic [CNT_W-1:0] credit_cnt;
   logic             idle;
   logic             err;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   credit_tx_if #(.WIDTH(FLIT_W)) bus ();

   credit_tx #(
      .WIDTH   (FLIT_W),
      .CREDITS (CR)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .link       (bus),
      .credit_in  (credit_in),
      .credit_cnt (credit_cnt),
      .idle       (idle),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [2:0]        lv;
   logic [FLIT_W-1:0] ld [3];
   logic [2:0]        cv;

   initial begin
      int unsigned sent, rcvd, cyc;
      logic        xf, rx_v;
      logic [FLIT_W-1:0] rx_d;

      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset state
      check("rst_cnt",   32'(credit_cnt),    32'd4);
      check("rst_ready", 32'(bus.in_ready),  32'd1);
      check("rst_idle",  32'(idle),          32'd1);
      check("rst_oval",  32'(bus.out_valid), 32'd0);
      check("rst_odata", 32'(bus.out_data),  32'd0);
      check("rst_err",   32'(err),           32'd0);

      // Burst of six with no credits back: only four go out
      for (int i = 0; i < 6; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = FLIT_W'(8'h10 + i);
         tick();
         check("burst_oval",  32'(bus.out_valid), (i < 4) ? 32'd1 : 32'd0);
         check("burst_odata", 32'(bus.out_data),  (i < 4) ? 32'(8'h10 + i) : 32'h13);
         check("burst_cnt",   32'(credit_cnt),    (i < 4) ? 32'(3 - i) : 32'd0);
         check("burst_ready", 32'(bus.in_ready),  (i < 3) ? 32'd1 : 32'd0);
      end
      bus.in_valid = 1'b0;
      check("stall_idle", 32'(idle), 32'd0);

      // Stall release by one credit, then spend it
      credit_in = 1'b1;
      tick();
      credit_in = 1'b0;
      check("rel_cnt",   32'(credit_cnt),   32'd1);
      check("rel_ready", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h14;
      tick();
      bus.in_valid = 1'b0;
      check("rel_oval",  32'(bus.out_valid), 32'd1);
      check("rel_odata", 32'(bus.out_data),  32'h14);
      check("rel_cnt0",  32'(credit_cnt),    32'd0);
      check("rel_ready0",32'(bus.in_ready),  32'd0);

      // Bring count to 2, then transfer and credit together
      credit_in = 1'b1;
      tick();
      tick();
      credit_in = 1'b0;
      check("sim_pre_cnt", 32'(credit_cnt), 32'd2);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h5A;
      credit_in    = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      credit_in    = 1'b0;
      check("sim_cnt",   32'(credit_cnt),    32'd2);
      check("sim_oval",  32'(bus.out_valid), 32'd1);
      check("sim_odata", 32'(bus.out_data),  32'h5A);
      tick();
      check("sim_oval_drop", 32'(bus.out_valid), 32'd0);
      check("sim_odata_hold",32'(bus.out_data),  32'h5A);

      // Refill to full, then overflow
      credit_in = 1'b1;
      tick();
      tick();
      credit_in = 1'b0;
      check("full_cnt",  32'(credit_cnt), 32'd4);
      check("full_idle", 32'(idle),       32'd1);
      check("full_err",  32'(err),        32'd0);
      credit_in = 1'b1;
      tick();
      credit_in = 1'b0;
      check("ovf_err", 32'(err),        32'd1);
      check("ovf_cnt", 32'(credit_cnt), 32'd4);

      // Ten cycles of traffic with matching credit return: err stays, count steady
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = FLIT_W'(8'hA0 + i);
         credit_in    = 1'b1;
         tick();
         check("ovf_hold_err",   32'(err),          32'd1);
         check("ovf_hold_cnt",   32'(credit_cnt),   32'd4);
         check("ovf_hold_odata", 32'(bus.out_data), 32'(8'hA0 + i));
      end
      bus.in_valid = 1'b0;
      credit_in    = 1'b0;

      // Reset mid-burst at count 1
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = FLIT_W'(8'h70 + i);
         tick();
      end
      check("mid_cnt",  32'(credit_cnt),    32'd1);
      check("mid_oval", 32'(bus.out_valid), 32'd1);
      bus.in_data = 8'h77;
      rst_n = 1'b0;
      #1;
      check("arst_oval",  32'(bus.out_valid), 32'd0);
      check("arst_cnt",   32'(credit_cnt),    32'd4);
      check("arst_err",   32'(err),           32'd0);
      check("arst_ready", 32'(bus.in_ready),  32'd1);
      check("arst_odata", 32'(bus.out_data),  32'd0);
      bus.in_valid = 1'b0;
      #3 rst_n = 1'b1;
      tick();

      // Loopback through two 3-deep delay lines: 100 flits in order
      lv = '0; cv = '0;
      for (int k = 0; k < 3; k++) ld[k] = '0;
      sent = 0; rcvd = 0; cyc = 0;
      while ((rcvd < 100 || !idle) && cyc < 2000) begin
         bus.in_valid = (sent < 100);
         bus.in_data  = FLIT_W'(sent);
         credit_in    = cv[2];
         xf = bus.in_valid && bus.in_ready;
         tick();
         cyc++;
         if (xf) sent++;
         rx_v  = lv[2];
         rx_d  = ld[2];
         lv    = {lv[1:0], bus.out_valid};
         ld[2] = ld[1];
         ld[1] = ld[0];
         ld[0] = bus.out_data;
         cv    = {cv[1:0], rx_v};
         if (rx_v) begin
            check("loop_data", 32'(rx_d), 32'(rcvd[7:0]));
            rcvd++;
         end
      end
      bus.in_valid = 1'b0;
      credit_in    = 1'b0;
      check("loop_rcvd", rcvd,            32'd100);
      check("loop_idle", 32'(idle),       32'd1);
      check("loop_cnt",  32'(credit_cnt), 32'd4);
      check("loop_err",  32'(err),        32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog expired");
   end
endmodule
